// File: rtl/mp_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module   : mp_addsub_seq
// Purpose  : Limb-serial multi-precision adder/subtractor. It processes one
//            LIMB-bit slice per cycle through a registered carry. It answers
//            a start/done handshake.
// Ports    : clk      - clock
//            resetn   - synchronous, active-low reset
//            start    - single-cycle request pulse; ignored unless idle
//            subtract - 0 = a+b, 1 = a-b (sampled with start)
//            in_a     - operand A, WIDTH bits (sampled with start)
//            in_b     - operand B, WIDTH bits (sampled with start)
//            result   - WIDTH+1 bit sum/difference, updated on DONE entry
//            done     - one-cycle completion pulse
// Options  : MP_ADDSUB_ZERO_SKIP_EN - when defined, a zero in_b finishes in
//            one cycle with result = {1'b0, in_a}
// Revision : 1.0 - initial release
// ============================================================================
module mp_addsub_seq #(
  parameter int WIDTH = 1027,
  parameter int LIMB  = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH:0]   result,
  output logic             done
);

  localparam int NL = (WIDTH + LIMB - 1) / LIMB;
  localparam int PW = NL * LIMB;
  localparam int KW = (NL > 1) ? $clog2(NL) : 1;
  localparam logic [KW-1:0] C_K_LAST = KW'(NL - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [KW-1:0]   r_k;
  logic            r_carry;
  logic [PW-1:0]   r_a;
  logic [PW-1:0]   r_b;
  logic [PW-1:0]   r_sum;
  logic [WIDTH:0]  r_result;
  logic [LIMB:0]   w_limb_sum;
  logic [PW-1:0]   w_sum_next;
  logic            w_accept;
  logic            w_unused_hi;

  assign w_accept = (r_state == S_IDLE) && start;

`ifdef MP_ADDSUB_ZERO_SKIP_EN
  logic w_b_zero;
  assign w_b_zero = (in_b == '0);
`endif

  // Operands shift right one limb per cycle, so the adder always works on
  // the low limb. Sum limbs enter at the top, so after NL cycles r_sum
  // holds the full result in place.
  assign w_limb_sum = {1'b0, r_a[LIMB-1:0]} + {1'b0, r_b[LIMB-1:0]}
                    + {{LIMB{1'b0}}, r_carry};
  assign w_sum_next = {w_limb_sum[LIMB-1:0], r_sum[PW-1:LIMB]};
  assign w_unused_hi = ^w_sum_next[PW-1:WIDTH+1];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
`ifdef MP_ADDSUB_ZERO_SKIP_EN
          w_next = w_b_zero ? S_DONE : S_RUN;
`else
          w_next = S_RUN;
`endif
        end
      end
      S_RUN: begin
        if (r_k == C_K_LAST) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand and sum registers carry no reset. Their contents do not matter
  // until a request loads them.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_k      <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_a     <= PW'(in_a);
      // Subtraction is a + ~b + 1 over the padded width. The +1 enters as
      // the initial carry.
      r_b     <= subtract ? ~(PW'(in_b)) : PW'(in_b);
      r_carry <= subtract;
      r_k     <= '0;
`ifdef MP_ADDSUB_ZERO_SKIP_EN
      if (w_b_zero) begin
        r_result <= {1'b0, in_a};
      end
`endif
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> LIMB;
      r_b     <= r_b >> LIMB;
      r_sum   <= w_sum_next;
      r_carry <= w_limb_sum[LIMB];
      if (r_k == C_K_LAST) begin
        r_k      <= '0;
        r_result <= w_sum_next[WIDTH:0];
      end else begin
        r_k <= r_k + KW'(1);
      end
    end
  end

  assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_mp_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mp_addsub_seq
// Purpose  : Self-checking bench for mp_addsub_seq. A cycle-level reference
//            model predicts done and result. Directed cases pin literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mp_addsub_seq;

  localparam int WIDTH = 1027;
  localparam int LIMB  = 64;
  localparam int NL    = 17;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             start = 1'b0;
  logic             subtract = 1'b0;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [WIDTH:0]   result;
  logic             done;

  always #5 clk = ~clk;

  mp_addsub_seq #(.WIDTH(WIDTH), .LIMB(LIMB)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .subtract (subtract),
    .in_a     (in_a),
    .in_b     (in_b),
    .result   (result),
    .done     (done)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic ok,
                       input logic [WIDTH:0] act, input logic [WIDTH:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got top=%0b low=%h, expected top=%0b low=%h",
               name, cyc, act[WIDTH], act[255:0], exp[WIDTH], exp[255:0]);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [WIDTH:0] ref_op(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic sub);
    logic [WIDTH:0] ea;
    logic [WIDTH:0] eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    return sub ? (ea - eb) : (ea + eb);
  endfunction

  function automatic int op_latency(input logic [WIDTH-1:0] b);
`ifdef MP_ADDSUB_ZERO_SKIP_EN
    if (b == '0) return 1;
`endif
    return NL + 1;
  endfunction

  int             done_cycle = -1;
  logic [WIDTH:0] pend       = '0;
  logic [WIDTH:0] exp_result = '0;

  always @(posedge clk) begin
    if (!resetn) begin
      done_cycle = -1;
      exp_result = '0;
    end else if (start && cyc > done_cycle) begin
      pend       = ref_op(in_a, in_b, subtract);
      done_cycle = cyc + op_latency(in_b);
    end
    cyc++;
    if (cyc == done_cycle) exp_result = pend;
  end

  always @(negedge clk) begin
    check("done_model", done === (cyc == done_cycle),
          (WIDTH+1)'(done), (WIDTH+1)'(cyc == done_cycle));
    check("result_model", result === exp_result, result, exp_result);
  end

  // ---------------- helpers ----------------
  function automatic logic [WIDTH-1:0] rnd_word();
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < 33; i++) v = {v[WIDTH-33:0], 32'($urandom())};
    return v;
  endfunction

  task automatic op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                    input logic sub, input int exp_lat,
                    input logic [WIDTH:0] exp_val, input string name);
    int t0;
    int seen;
    @(negedge clk);
    in_a = a; in_b = b; subtract = sub; start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    in_a = rnd_word(); in_b = rnd_word(); subtract = ~sub;
    seen = -1;
    for (int i = 0; i < 40 && seen < 0; i++) begin
      if (done) seen = cyc;
      else @(negedge clk);
    end
    check({name, "_latency"}, seen == t0 + exp_lat,
          (WIDTH+1)'(seen - t0), (WIDTH+1)'(exp_lat));
    check({name, "_value"}, result === exp_val, result, exp_val);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH:0]   two_pow_m2;
    logic [WIDTH-1:0] all1;
    int t0;
    int first;
    int pulses;
    int zlat;

    all1 = '1;
    two_pow_m2 = '1;
    two_pow_m2[0] = 1'b0;
`ifdef MP_ADDSUB_ZERO_SKIP_EN
    zlat = 1;
`else
    zlat = NL + 1;
`endif

    repeat (3) @(negedge clk);
    check("reset_done", done === 1'b0, (WIDTH+1)'(done), '0);
    check("reset_result", result === '0, result, '0);
    resetn = 1'b1;

    op(all1, all1, 1'b0, NL + 1, two_pow_m2, "max_add");
    op(WIDTH'(5), WIDTH'(3), 1'b1, NL + 1, (WIDTH+1)'(2), "small_sub");
    op(WIDTH'(3), WIDTH'(5), 1'b1, NL + 1, two_pow_m2, "neg_sub");
    op(WIDTH'(12'h123), '0, 1'b0, zlat, (WIDTH+1)'(12'h123), "zero_skip");
    op(WIDTH'(12'h456), '0, 1'b1, zlat, (WIDTH+1)'(12'h456), "zero_skip_sub");

    // A second start while busy must be ignored.
    @(negedge clk);
    in_a = WIDTH'(1); in_b = WIDTH'(1); subtract = 1'b0; start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    in_a = WIDTH'(7); in_b = WIDTH'(7); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    first = -1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        pulses++;
        if (first < 0) begin
          first = cyc;
          check("busy_value", result === (WIDTH+1)'(2), result, (WIDTH+1)'(2));
        end
      end
      @(negedge clk);
    end
    check("busy_pulses", pulses == 1, (WIDTH+1)'(pulses), (WIDTH+1)'(1));
    check("busy_latency", first == t0 + NL + 1,
          (WIDTH+1)'(first - t0), (WIDTH+1)'(NL + 1));

    // Reset in the middle of an operation.
    @(negedge clk);
    in_a = rnd_word(); in_b = rnd_word(); subtract = 1'b0; start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("midrst_done", done === 1'b0, (WIDTH+1)'(done), '0);
    check("midrst_result", result === '0, result, '0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) check("midrst_no_done", 1'b0, (WIDTH+1)'(done), '0);
    end
    op(WIDTH'(10), WIDTH'(4), 1'b1, NL + 1, (WIDTH+1)'(6), "rst_then_sub");

    // Randomized traffic: busy starts, zero/equal operands, stray resets.
    for (int i = 0; i < 900; i++) begin
      @(negedge clk);
      start    = ($urandom_range(0, 4) == 0);
      subtract = 1'($urandom());
      in_a     = ($urandom_range(0, 15) == 0) ? all1 : rnd_word();
      case ($urandom_range(0, 7))
        0:       in_b = '0;
        1:       in_b = in_a;
        2:       in_b = all1;
        default: in_b = rnd_word();
      endcase
      resetn = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk);
    start = 1'b0;
    resetn = 1'b1;
    repeat (NL + 4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
